pipe4_datapath: RTL and testbench

Four-stage register–ALU–memory pipeline and the consumer of the two-phase clocking scheme, re-expressed on a single edge.
- S1: register-file operand fetch.
- S2: ALU.
- S3: register-file write-back.
- S4: data-memory write.
- One instruction is accepted per cycle, with no stalls. Full forwarding removes every read-after-write hazard.

---
 rtl/pipe4_pkg.sv | 52 +++++
 rtl/pipe4_alu.sv | 34 +++
 rtl/pipe4_datapath.sv | 108 ++++++++++
 tb/tb_pipe4_datapath.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe4_pkg.sv
// Purpose: shared widths, ALU opcodes and pipeline-register layouts for the
//          pipe4 datapath (operand fetch -> ALU -> write-back -> memory).
// Contents:
//   DW / RA / MA   data, register-address and memory-address widths
//   FN_*           ALU opcodes
//   s1_reg_t       fetch -> ALU register (R1)
//   s2_reg_t       ALU -> write-back register (R2)
//   s3_reg_t       write-back -> memory register (R3)
package pipe4_pkg;

    localparam int DW   = 16;
    localparam int RA   = 4;
    localparam int MA   = 8;
    localparam int NREG = 1 << RA;
    localparam int NMEM = 1 << MA;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_MUL  = 4'd2;
    localparam logic [3:0] FN_PASA = 4'd3;
    localparam logic [3:0] FN_PASB = 4'd4;
    localparam logic [3:0] FN_AND  = 4'd5;
    localparam logic [3:0] FN_OR   = 4'd6;
    localparam logic [3:0] FN_XOR  = 4'd7;
    localparam logic [3:0] FN_NEG  = 4'd8;
    localparam logic [3:0] FN_NOT  = 4'd9;
    localparam logic [3:0] FN_SRL1 = 4'd10;
    localparam logic [3:0] FN_SLL1 = 4'd11;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [RA-1:0] rd;
        logic [3:0]    func;
        logic [MA-1:0] addr;
    } s1_reg_t;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] z;
        logic [RA-1:0] rd;
        logic [MA-1:0] addr;
    } s2_reg_t;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] z;
        logic [MA-1:0] addr;
    } s3_reg_t;

endpackage

// File: rtl/pipe4_alu.sv
// Purpose: combinational ALU used by the second pipeline stage.
// Ports:
//   i_a, i_b  operands (DW bits)
//   i_func    opcode (FN_*); opcodes 12..15 produce zero
//   o_z       result, truncated to DW bits
module pipe4_alu
    import pipe4_pkg::*;
(
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [3:0]    i_func,
    output logic [DW-1:0] o_z
);

    always_comb begin
        o_z = '0;
        case (i_func)
            FN_ADD:  o_z = i_a + i_b;
            FN_SUB:  o_z = i_a - i_b;
            FN_MUL:  o_z = i_a * i_b;   // context width keeps the low DW bits
            FN_PASA: o_z = i_a;
            FN_PASB: o_z = i_b;
            FN_AND:  o_z = i_a & i_b;
            FN_OR:   o_z = i_a | i_b;
            FN_XOR:  o_z = i_a ^ i_b;
            FN_NEG:  o_z = -i_a;
            FN_NOT:  o_z = ~i_a;
            FN_SRL1: o_z = i_a >> 1;
            FN_SLL1: o_z = i_a << 1;
            default: o_z = '0;
        endcase
    end

endmodule

// File: rtl/pipe4_datapath.sv
// Purpose: four-stage register/ALU/memory pipeline with full forwarding.
//   S1 operand fetch -> R1, S2 ALU -> R2, S3 regfile write -> R3,
//   S4 data-memory write from R3.
// Ports:
//   master              clock, all state on posedge
//   rst_n               asynchronous active-low reset
//   in_valid            instruction present this cycle
//   rs1, rs2, rd        source A/B and destination register
//   func                ALU opcode
//   addr                memory write address
//   out_valid/out_z/out_addr   memory write committing this cycle (R3)
//   dbg_ra -> dbg_rd    combinational register-file read
//   dbg_ma -> dbg_md    combinational data-memory read
//
// Valid semantics: there is no back-pressure. Every cycle with in_valid=1
// launches exactly one instruction; the v bit travels with it through
// R1/R2/R3 and qualifies both the regfile write (out of R2) and the memory
// write (out of R3). Clearing a v bit is the only way a write is suppressed.
module pipe4_datapath
    import pipe4_pkg::*;
(
    input  logic          master,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [RA-1:0] rs1,
    input  logic [RA-1:0] rs2,
    input  logic [RA-1:0] rd,
    input  logic [3:0]    func,
    input  logic [MA-1:0] addr,
    output logic          out_valid,
    output logic [DW-1:0] out_z,
    output logic [MA-1:0] out_addr,
    input  logic [RA-1:0] dbg_ra,
    output logic [DW-1:0] dbg_rd,
    input  logic [MA-1:0] dbg_ma,
    output logic [DW-1:0] dbg_md
);

    s1_reg_t       r_s1;
    s2_reg_t       r_s2;
    s3_reg_t       r_s3;
    logic [DW-1:0] r_rf  [NREG];
    logic [DW-1:0] r_mem [NMEM];

    logic [DW-1:0] w_alu_z;
    logic [DW-1:0] w_opa;
    logic [DW-1:0] w_opb;

    pipe4_alu u_alu (
        .i_a    (r_s1.a),
        .i_b    (r_s1.b),
        .i_func (r_s1.func),
        .o_z    (w_alu_z)
    );

    // Forwarding: the younger producer (still in the ALU) overrides the older
    // one in R2, which overrides the regfile. Distance 3+ needs no bypass
    // because R2 has already been written to the regfile on that edge.
    always_comb begin
        w_opa = r_rf[rs1];
        if (r_s2.v && (r_s2.rd == rs1)) w_opa = r_s2.z;
        if (r_s1.v && (r_s1.rd == rs1)) w_opa = w_alu_z;

        w_opb = r_rf[rs2];
        if (r_s2.v && (r_s2.rd == rs2)) w_opb = r_s2.z;
        if (r_s1.v && (r_s1.rd == rs2)) w_opb = w_alu_z;
    end

    always_ff @(posedge master or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else begin
            r_s1.v    <= in_valid;
            r_s1.a    <= w_opa;
            r_s1.b    <= w_opb;
            r_s1.rd   <= rd;
            r_s1.func <= func;
            r_s1.addr <= addr;

            r_s2.v    <= r_s1.v;
            r_s2.z    <= w_alu_z;
            r_s2.rd   <= r_s1.rd;
            r_s2.addr <= r_s1.addr;

            r_s3.v    <= r_s2.v;
            r_s3.z    <= r_s2.z;
            r_s3.addr <= r_s2.addr;

            if (r_s2.v) r_rf[r_s2.rd] <= r_s2.z;
        end
    end

    // Data memory keeps its contents across reset; an in-flight write is
    // dropped only because reset clears R3.v.
    always_ff @(posedge master) begin
        if (r_s3.v) r_mem[r_s3.addr] <= r_s3.z;
    end

    assign out_valid = r_s3.v;
    assign out_z     = r_s3.z;
    assign out_addr  = r_s3.addr;
    assign dbg_rd    = r_rf[dbg_ra];
    assign dbg_md    = r_mem[dbg_ma];

endmodule

// File: tb/tb_pipe4_datapath.sv
// Directed bench for pipe4_datapath: a table of back-to-back instructions
// with hand-computed results, plus hand-written sequences for forwarding
// distance, truncation, same-destination bursts and reset mid-flight.
// A negedge monitor checks every memory-write commit against exp_q.
module tb_pipe4_datapath;

    logic        master;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  rs1, rs2, rd, func;
    logic [7:0]  addr;
    logic        out_valid;
    logic [15:0] out_z;
    logic [7:0]  out_addr;
    logic [3:0]  dbg_ra;
    logic [15:0] dbg_rd;
    logic [7:0]  dbg_ma;
    logic [15:0] dbg_md;

    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q[$];   // {addr, z} of each expected memory commit

    typedef struct {
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [3:0]  func;
        logic [7:0]  addr;
        logic [15:0] exp;
        bit          chk_rd;
    } vec_t;

    vec_t tbl[16];

    pipe4_datapath dut (
        .master    (master),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .addr      (addr),
        .out_valid (out_valid),
        .out_z     (out_z),
        .out_addr  (out_addr),
        .dbg_ra    (dbg_ra),
        .dbg_rd    (dbg_rd),
        .dbg_ma    (dbg_ma),
        .dbg_md    (dbg_md)
    );

    // ---------------- clock / reset ----------------
    initial begin
        master = 1'b0;
        forever #5 master = ~master;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge master);
        #1;
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input logic [3:0] f, input logic [7:0] ad, input logic [15:0] z);
        rs1 = a; rs2 = b; rd = d; func = f; addr = ad;
        in_valid = 1'b1;
        exp_q.push_back({ad, z});
        @(posedge master);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [3:0] idx, input logic [15:0] exp);
        dbg_ra = idx;
        #1;
        check(name, dbg_rd, exp);
    endtask

    task automatic chk_mem(input string name, input logic [7:0] a, input logic [15:0] exp);
        dbg_ma = a;
        #1;
        check(name, dbg_md, exp);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge master) begin
        logic [23:0] e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=addr %h z %h required=no_commit", out_addr, out_z);
            end else begin
                e = exp_q.pop_front();
                check("sb_out_addr", out_addr, e[23:16]);
                check("sb_out_z", out_z, e[15:0]);
            end
        end
    end

    // ---------------- test ----------------
    initial begin
        // ALU opcodes: 0 ADD 1 SUB 2 MUL 3 PASA 4 PASB 5 AND 6 OR 7 XOR
        //              8 NEG 9 NOT 10 SRL1 11 SLL1 12..15 zero
        tbl[0]  = '{4'd0,  4'd0,  4'd14, 4'd9,  8'hF0, 16'hFFFF, 1'b1}; // ~r0
        tbl[1]  = '{4'd14, 4'd0,  4'd13, 4'd8,  8'hF1, 16'h0001, 1'b1}; // -r14 (dist 1)
        tbl[2]  = '{4'd13, 4'd0,  4'd12, 4'd11, 8'hF2, 16'h0002, 1'b1}; // r13<<1
        tbl[3]  = '{4'd13, 4'd12, 4'd11, 4'd0,  8'hF3, 16'h0003, 1'b1}; // dist 2 + dist 1
        tbl[4]  = '{4'd12, 4'd0,  4'd10, 4'd11, 8'hF4, 16'h0004, 1'b1};
        tbl[5]  = '{4'd10, 4'd13, 4'd15, 4'd0,  8'hF5, 16'h0005, 1'b1};
        tbl[6]  = '{4'd15, 4'd0,  4'd1,  4'd3,  8'hF6, 16'h0005, 1'b1}; // r1 = 5
        tbl[7]  = '{4'd14, 4'd11, 4'd2,  4'd4,  8'hF7, 16'h0003, 1'b1}; // r2 = 3
        tbl[8]  = '{4'd14, 4'd0,  4'd7,  4'd3,  8'hF8, 16'hFFFF, 1'b1}; // r7 = FFFF
        tbl[9]  = '{4'd0,  4'd13, 4'd8,  4'd4,  8'hF9, 16'h0001, 1'b1}; // r8 = 1
        tbl[10] = '{4'd7,  4'd11, 4'd0,  4'd5,  8'hFA, 16'h0003, 1'b0}; // AND
        tbl[11] = '{4'd10, 4'd13, 4'd0,  4'd6,  8'hFB, 16'h0005, 1'b0}; // OR
        tbl[12] = '{4'd7,  4'd0,  4'd0,  4'd10, 8'hFC, 16'h7FFF, 1'b0}; // SRL1
        tbl[13] = '{4'd13, 4'd12, 4'd0,  4'd1,  8'hFD, 16'hFFFF, 1'b0}; // SUB wrap
        tbl[14] = '{4'd7,  4'd7,  4'd0,  4'd12, 8'hFE, 16'h0000, 1'b0}; // opcode 12
        tbl[15] = '{4'd1,  4'd2,  4'd0,  4'd7,  8'hFF, 16'h0006, 1'b1}; // r0 is ordinary

        rst_n = 1'b0; in_valid = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0;
        dbg_ra = '0; dbg_ma = '0;
        repeat (3) @(posedge master);
        #1 rst_n = 1'b1;

        // reset then idle
        for (int i = 0; i < 16; i++) chk_reg($sformatf("reset_r%0d", i), 4'(i), 16'h0000);
        sync();
        for (int i = 0; i < 10; i++) begin
            check("idle_out_valid", out_valid, 1'b0);
            sync();
        end

        // table: back-to-back, every row writes regfile and memory
        for (int i = 0; i < 16; i++)
            issue(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].func, tbl[i].addr, tbl[i].exp);
        repeat (4) sync();
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].chk_rd) chk_reg($sformatf("tbl%0d_rd", i), tbl[i].rd, tbl[i].exp);
            chk_mem($sformatf("tbl%0d_mem", i), tbl[i].addr, tbl[i].exp);
        end
        sync();

        // dependent chain, no bubble, with latency checks
        issue(4'd1, 4'd2, 4'd3, 4'd0, 8'h11, 16'h0008);   // r3 = r1 + r2
        issue(4'd3, 4'd1, 4'd4, 4'd1, 8'h10, 16'h0003);   // r4 = r3 - r1
        sync();
        chk_reg("chain_r3_at_k2", 4'd3, 16'h0008);
        sync();
        chk_reg("chain_r4_at_k2", 4'd4, 16'h0003);
        sync();
        chk_mem("chain_mem10_at_k3", 8'h10, 16'h0003);
        sync();

        // distance-2 forward across a NOP cycle
        issue(4'd1, 4'd2, 4'd5, 4'd2, 8'h12, 16'h000F);   // r5 = r1 * r2
        sync();
        issue(4'd5, 4'd1, 4'd6, 4'd7, 8'h13, 16'h000A);   // r6 = r5 ^ r1
        repeat (3) sync();
        chk_reg("dist2_r5", 4'd5, 16'h000F);
        chk_reg("dist2_r6", 4'd6, 16'h000A);
        sync();

        // wrap and truncation
        issue(4'd7,  4'd8,  4'd3, 4'd0,  8'h14, 16'h0000); // FFFF + 1
        issue(4'd7,  4'd0,  4'd4, 4'd10, 8'h15, 16'h7FFF);
        issue(4'd4,  4'd0,  4'd4, 4'd9,  8'h16, 16'h8000); // ~r4, self-dependent
        issue(4'd4,  4'd0,  4'd5, 4'd11, 8'h17, 16'h0000); // 8000 << 1
        issue(4'd10, 4'd10, 4'd6, 4'd2,  8'h18, 16'h0010);
        issue(4'd6,  4'd6,  4'd6, 4'd2,  8'h19, 16'h0100);
        issue(4'd6,  4'd6,  4'd0, 4'd2,  8'h1A, 16'h0000); // 0100 * 0100
        repeat (3) sync();
        chk_reg("wrap_add_r3", 4'd3, 16'h0000);
        chk_reg("wrap_not_r4", 4'd4, 16'h8000);
        chk_reg("wrap_sll_r5", 4'd5, 16'h0000);
        chk_reg("wrap_mul_r6", 4'd6, 16'h0100);
        chk_reg("wrap_mul_r0", 4'd0, 16'h0000);
        sync();

        // same-destination burst; the last read must see the youngest write
        issue(4'd13, 4'd0, 4'd9, 4'd3, 8'h20, 16'h0001);
        issue(4'd12, 4'd0, 4'd9, 4'd3, 8'h20, 16'h0002);
        issue(4'd11, 4'd0, 4'd9, 4'd3, 8'h20, 16'h0003);
        issue(4'd9,  4'd0, 4'd3, 4'd3, 8'h21, 16'h0003);
        repeat (4) sync();
        chk_reg("burst_r9", 4'd9, 16'h0003);
        chk_reg("burst_r3", 4'd3, 16'h0003);
        chk_mem("burst_mem20", 8'h20, 16'h0003);
        chk_mem("burst_mem21", 8'h21, 16'h0003);
        sync();

        // reset mid-flight: seed four words, then interrupt the pipe
        for (int i = 0; i < 4; i++) issue(4'd13, 4'd0, 4'd15, 4'd3, 8'(8'h30 + i), 16'h0001);
        repeat (4) sync();
        issue(4'd14, 4'd14, 4'd14, 4'd0, 8'h33, 16'hFFFE); // reaches R3 before reset
        issue(4'd1,  4'd1,  4'd1,  4'd0, 8'h30, 16'h000A); // I1 at edge k
        issue(4'd2,  4'd2,  4'd2,  4'd0, 8'h31, 16'h0006); // I2 at edge k+1
        check("pre_reset_out_valid", out_valid, 1'b1);
        rs1 = 4'd8; rs2 = 4'd8; rd = 4'd8; func = 4'd0; addr = 8'h32;
        in_valid = 1'b1;                                    // I3 presented
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_z", out_z, 16'h0000);
        check("rst_out_addr", out_addr, 8'h00);
        sync();
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) chk_reg($sformatf("midrst_r%0d", i), 4'(i), 16'h0000);
        for (int i = 0; i < 4; i++) chk_mem($sformatf("midrst_mem%0d", i), 8'(8'h30 + i), 16'h0001);
        sync();
        for (int i = 0; i < 10; i++) begin
            check("post_rst_out_valid", out_valid, 1'b0);
            sync();
        end
        for (int i = 0; i < 4; i++) chk_mem($sformatf("post_rst_mem%0d", i), 8'(8'h30 + i), 16'h0001);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
